// File: rtl/clk_div_pkg.sv
// Shared types and constants for the clock-divider configuration controller.
package clk_div_pkg;

  typedef enum logic [2:0] {
    IDLE,
    HDR,
    CHKB,
    EVAL,
    WAIT_EDGE,
    APPLY
  } state_e;

  localparam logic [7:0] HDR_BYTE = 8'hA5;

  localparam logic [1:0] ERR_NONE  = 2'd0;
  localparam logic [1:0] ERR_CSUM  = 2'd1;
  localparam logic [1:0] ERR_TMO   = 2'd2;
  localparam logic [1:0] ERR_RANGE = 2'd3;

endpackage

// File: rtl/clk_div_cfg_ctrl_if.sv
// Byte-wide valid/ready stream from the UART receiver into the config controller.
interface clk_div_cfg_ctrl_if;

  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;

  modport master (output rx_data, output rx_valid, input rx_ready);
  modport slave  (input rx_data, input rx_valid, output rx_ready);

endinterface

// File: rtl/clk_div_frame_rx.sv
// Frame receive datapath: header detect, little-endian assembly, running XOR and
// the inter-byte gap counter. Sequencing state is owned by the top level.
module clk_div_frame_rx
  import clk_div_pkg::*;
#(
  parameter int unsigned TIMEOUT = 100000
) (
  input  logic        clk_in,
  input  logic        reset,
  input  state_e      state,
  input  logic        xfer,
  input  logic [7:0]  rx_data,
  output logic [31:0] frame_val,
  output logic        csum_ok,
  output logic        hdr_det,
  output logic        data_last,
  output logic        frame_done,
  output logic        timeout
);

  logic [1:0]  cnt_q;
  logic [31:0] shift_q;
  logic [7:0]  xor_q;
  logic        csum_ok_q;
  logic [31:0] gap_q;
  logic        in_frame;

  assign in_frame   = (state == HDR) || (state == CHKB);
  assign hdr_det    = xfer && (state == IDLE) && (rx_data == HDR_BYTE);
  assign data_last  = xfer && (state == HDR) && (cnt_q == 2'd3);
  assign frame_done = xfer && (state == CHKB);
  // A transfer on the expiry cycle takes priority over the timeout.
  assign timeout    = in_frame && !xfer && (gap_q == 32'(TIMEOUT));
  assign frame_val  = shift_q;
  assign csum_ok    = csum_ok_q;

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      cnt_q     <= 2'd0;
      shift_q   <= 32'd0;
      xor_q     <= 8'd0;
      csum_ok_q <= 1'b0;
      gap_q     <= 32'd0;
    end else begin
      if (hdr_det) begin
        cnt_q <= 2'd0;
        xor_q <= 8'd0;
      end
      if (xfer && (state == HDR)) begin
        // First data byte ends up in the low byte after four shifts.
        shift_q <= {rx_data, shift_q[31:8]};
        xor_q   <= xor_q ^ rx_data;
        cnt_q   <= cnt_q + 2'd1;
      end
      if (frame_done) begin
        csum_ok_q <= (rx_data == xor_q);
      end
      if (!in_frame || xfer) begin
        gap_q <= 32'd0;
      end else if (gap_q != 32'hFFFF_FFFF) begin
        gap_q <= gap_q + 32'd1;
      end
    end
  end

endmodule

// File: rtl/clk_div_cfg_ctrl.sv
// Configuration controller: validates divide-value frames and applies them to the
// divider on a falling edge of the divided clock, followed by a one-cycle reset.
module clk_div_cfg_ctrl
  import clk_div_pkg::*;
#(
  parameter logic [31:0] DEFAULT_FREQ = 32'd50,
  parameter logic [31:0] MIN_FREQ     = 32'd2,
  parameter logic [31:0] MAX_FREQ     = 32'hFFFF_FFF0,
  parameter int unsigned TIMEOUT      = 100000
) (
  input  logic                clk_in,
  input  logic                reset,
  clk_div_cfg_ctrl_if.slave   rx,
  input  logic                div_clk,
  output logic [31:0]         freq_val,
  output logic                div_rst,
  output logic                busy,
  output logic                cfg_done,
  output logic                err_valid,
  output logic [1:0]          err_code
);

  state_e      state_q;
  logic        div_clk_q;
  logic        xfer;
  logic        div_fall;
  logic [31:0] frame_val;
  logic        csum_ok;
  logic        hdr_det;
  logic        data_last;
  logic        frame_done;
  logic        timeout;

  assign rx.rx_ready = (state_q == IDLE) || (state_q == HDR) || (state_q == CHKB);
  assign busy        = (state_q != IDLE);
  assign xfer        = rx.rx_valid && rx.rx_ready;
  assign div_fall    = div_clk_q && !div_clk;

  clk_div_frame_rx #(
    .TIMEOUT (TIMEOUT)
  ) u_frame_rx (
    .clk_in     (clk_in),
    .reset      (reset),
    .state      (state_q),
    .xfer       (xfer),
    .rx_data    (rx.rx_data),
    .frame_val  (frame_val),
    .csum_ok    (csum_ok),
    .hdr_det    (hdr_det),
    .data_last  (data_last),
    .frame_done (frame_done),
    .timeout    (timeout)
  );

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      div_clk_q <= 1'b0;
      freq_val  <= DEFAULT_FREQ;
      div_rst   <= 1'b0;
      cfg_done  <= 1'b0;
      err_valid <= 1'b0;
      err_code  <= ERR_NONE;
    end else begin
      div_clk_q <= div_clk;
      div_rst   <= 1'b0;
      cfg_done  <= 1'b0;
      err_valid <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (hdr_det) state_q <= HDR;
        end
        HDR: begin
          if (timeout) begin
            state_q   <= IDLE;
            err_valid <= 1'b1;
            err_code  <= ERR_TMO;
          end else if (data_last) begin
            state_q <= CHKB;
          end
        end
        CHKB: begin
          if (timeout) begin
            state_q   <= IDLE;
            err_valid <= 1'b1;
            err_code  <= ERR_TMO;
          end else if (frame_done) begin
            state_q <= EVAL;
          end
        end
        EVAL: begin
          // Checksum takes precedence; only one error per frame.
          if (!csum_ok) begin
            state_q   <= IDLE;
            err_valid <= 1'b1;
            err_code  <= ERR_CSUM;
          end else if ((frame_val < MIN_FREQ) || (frame_val > MAX_FREQ)) begin
            state_q   <= IDLE;
            err_valid <= 1'b1;
            err_code  <= ERR_RANGE;
          end else begin
            state_q <= WAIT_EDGE;
          end
        end
        WAIT_EDGE: begin
          // New value lands together with the divider reset so it restarts cleanly.
          if (div_fall) begin
            state_q  <= APPLY;
            freq_val <= frame_val;
            div_rst  <= 1'b1;
            cfg_done <= 1'b1;
          end
        end
        APPLY: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_clk_div_cfg_ctrl.sv
// Scoreboard bench for clk_div_cfg_ctrl: directed plus randomized frames checked
// against an arithmetic frame model.
module tb_clk_div_cfg_ctrl;
  import clk_div_pkg::*;

  localparam int unsigned TMO  = 20;
  localparam logic [31:0] DEF  = 32'd50;
  localparam logic [31:0] MINF = 32'd2;
  localparam logic [31:0] MAXF = 32'hFFFF_FFF0;

  typedef struct packed {
    logic        is_err;
    logic [1:0]  code;
    logic [31:0] val;
  } exp_t;

  logic        clk_in = 1'b0;
  logic        reset  = 1'b1;
  logic        div_clk = 1'b0;
  logic        div_en  = 1'b1;
  int          half    = 4;
  logic [31:0] freq_val;
  logic        div_rst, busy, cfg_done, err_valid;
  logic [1:0]  err_code;

  exp_t        sb[$];
  exp_t        e;
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] model_freq = DEF;
  logic        apply_prev = 1'b0;

  clk_div_cfg_ctrl_if rx_if ();

  clk_div_cfg_ctrl #(
    .DEFAULT_FREQ (DEF),
    .MIN_FREQ     (MINF),
    .MAX_FREQ     (MAXF),
    .TIMEOUT      (TMO)
  ) dut (
    .clk_in    (clk_in),
    .reset     (reset),
    .rx        (rx_if),
    .div_clk   (div_clk),
    .freq_val  (freq_val),
    .div_rst   (div_rst),
    .busy      (busy),
    .cfg_done  (cfg_done),
    .err_valid (err_valid),
    .err_code  (err_code)
  );

  always #5 clk_in = ~clk_in;

  initial begin
    forever begin
      repeat (half) @(negedge clk_in);
      if (div_en) div_clk = ~div_clk;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_b(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b, expected %b at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] xsum(input logic [31:0] v);
    return v[7:0] ^ v[15:8] ^ v[23:16] ^ v[31:24];
  endfunction

  // Outcome of one complete frame carrying value v and checksum byte c.
  function automatic exp_t model(input logic [31:0] v, input logic [7:0] c);
    exp_t r;
    r.val = v;
    if (c != xsum(v)) begin
      r.is_err = 1'b1;
      r.code   = ERR_CSUM;
    end else if (v < MINF || v > MAXF) begin
      r.is_err = 1'b1;
      r.code   = ERR_RANGE;
    end else begin
      r.is_err = 1'b0;
      r.code   = ERR_NONE;
    end
    return r;
  endfunction

  // Monitor: pops the scoreboard whenever the DUT reports an outcome.
  always @(negedge clk_in) begin
    if (reset) begin
      model_freq = DEF;
      apply_prev = 1'b0;
    end else begin
      if (apply_prev) begin
        check_b("div_rst_one_cycle", div_rst, 1'b0);
        check_b("ready_after_apply", rx_if.rx_ready, 1'b1);
        apply_prev = 1'b0;
      end
      if (div_rst || cfg_done) check_b("div_rst_with_cfg_done", div_rst, cfg_done);
      if (err_valid || cfg_done) begin
        if (sb.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_event: err_valid=%b cfg_done=%b, expected none at %0t",
                   err_valid, cfg_done, $time);
        end else begin
          e = sb.pop_front();
          check_b("event_kind", err_valid, e.is_err);
          if (e.is_err) begin
            check("err_code", 32'(err_code), 32'(e.code));
            check("freq_unchanged", freq_val, model_freq);
            check_b("ready_after_err", rx_if.rx_ready, 1'b1);
          end else begin
            check("freq_val", freq_val, e.val);
            check_b("busy_in_apply", busy, 1'b1);
            model_freq = e.val;
            apply_prev = 1'b1;
          end
        end
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input int gap);
    int n = 0;
    repeat (gap) @(negedge clk_in);
    @(negedge clk_in);
    rx_if.rx_data  = b;
    rx_if.rx_valid = 1'b1;
    while (!rx_if.rx_ready && n < 500) begin
      @(negedge clk_in);
      n++;
    end
    if (n >= 500) begin
      n_cmp++;
      n_bad++;
      $display("FAIL send_stall: rx_ready=0 for %0d cycles, expected 1", n);
    end
    @(posedge clk_in);
    #1 rx_if.rx_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 3000) begin
      @(negedge clk_in);
      n++;
    end
    if (sb.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL outcome_wait: %0d outcomes pending, expected 0", sb.size());
      sb.delete();
    end
    repeat (2) @(negedge clk_in);
  endtask

  task automatic send_frame(input logic [31:0] v, input logic [7:0] c, input int chk_gap);
    sb.push_back(model(v, c));
    send_byte(HDR_BYTE, int'($urandom_range(3)));
    for (int i = 0; i < 4; i++) send_byte(v[8*i +: 8], int'($urandom_range(3)));
    send_byte(c, (chk_gap < 0) ? int'($urandom_range(3)) : chk_gap);
    drain();
  endtask

  initial begin
    logic [31:0] v;
    logic [7:0]  c;
    logic [7:0]  junk;
    int          kind;

    rx_if.rx_data  = 8'h00;
    rx_if.rx_valid = 1'b0;
    @(negedge clk_in);
    check("rst_freq_val", freq_val, DEF);
    check_b("rst_div_rst", div_rst, 1'b0);
    check_b("rst_cfg_done", cfg_done, 1'b0);
    check_b("rst_err_valid", err_valid, 1'b0);
    check("rst_err_code", 32'(err_code), 32'(ERR_NONE));
    check_b("rst_busy", busy, 1'b0);
    check_b("rst_rx_ready", rx_if.rx_ready, 1'b1);
    #2 reset = 1'b0;

    // Directed frames.
    send_frame(32'd1000, 8'hEB, -1);
    send_frame(32'd1000, 8'h00, -1);
    send_frame(32'd1, 8'h01, -1);
    sb.push_back('{is_err: 1'b1, code: ERR_TMO, val: 32'd0});
    send_byte(HDR_BYTE, 0);
    send_byte(8'h10, 0);
    drain();
    send_frame(32'h0000_0100, 8'h01, -1);
    send_byte(8'h33, 0);
    send_frame(32'h0000_00A5, 8'hA5, -1);
    // Checksum byte lands exactly on the expiry cycle: transfer wins.
    send_frame(32'd777, xsum(32'd777), int'(TMO));
    // One cycle later it is a timeout; the stray checksum byte is then ignored.
    sb.push_back('{is_err: 1'b1, code: ERR_TMO, val: 32'd0});
    send_byte(HDR_BYTE, 0);
    for (int i = 0; i < 4; i++) send_byte(8'h00, 0);
    send_byte(8'h01, int'(TMO) + 1);
    drain();
    send_frame(MINF, xsum(MINF), -1);
    send_frame(MAXF, xsum(MAXF), -1);
    send_frame(MAXF + 32'd1, xsum(MAXF + 32'd1), -1);
    send_frame(32'd777, xsum(32'd777), -1);

    // Randomized frames.
    for (int k = 0; k < 30; k++) begin
      half = int'($urandom_range(1, 6));
      if ($urandom_range(3) == 0) begin
        junk = 8'($urandom_range(255));
        if (junk != HDR_BYTE) send_byte(junk, 0);
      end
      kind = int'($urandom_range(3));
      v    = $urandom;
      if (kind == 3) begin
        case ($urandom_range(3))
          0:       v = 32'd0;
          1:       v = 32'd1;
          2:       v = 32'hFFFF_FFFF;
          default: v = MAXF + 32'd1 + 32'($urandom_range(13));
        endcase
      end
      c = xsum(v);
      if (kind == 2) c = c ^ 8'($urandom_range(1, 255));
      send_frame(v, c, -1);
    end

    // Reset while waiting for the apply edge.
    half   = 4;
    div_en = 1'b0;
    send_byte(HDR_BYTE, 0);
    send_byte(8'hE8, 0);
    send_byte(8'h03, 0);
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    send_byte(8'hEB, 0);
    repeat (3) @(negedge clk_in);
    check_b("wait_edge_busy", busy, 1'b1);
    check_b("wait_edge_not_ready", rx_if.rx_ready, 1'b0);
    #2 reset = 1'b1;
    #1;
    check("reset_freq_val", freq_val, DEF);
    check_b("reset_busy", busy, 1'b0);
    check_b("reset_cfg_done", cfg_done, 1'b0);
    check_b("reset_div_rst", div_rst, 1'b0);
    @(negedge clk_in);
    #2 reset = 1'b0;
    div_en = 1'b1;
    repeat (40) @(negedge clk_in);
    check("post_reset_freq_val", freq_val, DEF);
    check_b("post_reset_idle", busy, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule
